// File: rtl/image_link_pkg.sv
// Shared definitions for the image link. Both the receive and transmit sides use these.
package image_link_pkg;

  localparam int ADDR_W     = 17;
  localparam int PIX_W      = 12;
  localparam int NUM_PIXELS = 76800;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Marker pixel that opens a frame when the receiver is idle
  localparam pixel_t START_PIXEL = 12'h00A;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    DONE
  } frame_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver. It has a 2-flop input synchronizer and checks the start bit at half-bit.
// byte_valid pulses for one cycle when a good stop bit is seen.
// frame_err pulses for one cycle when the stop bit is sampled low.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t        r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;

  // Bring the asynchronous line into the clock domain, and keep one more stage for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Receive state machine: the start bit is rechecked at half-bit, and later bits are sampled at mid-bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= RX_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_prev && !r_sync2) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            // If the line is high again at half-bit, the low pulse was a glitch and is dropped
            r_state <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_cnt == BIT_M1) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_cnt == BIT_M1) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_sync2) begin
              byte_out   <= r_shift;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/image_receiver.sv
// Receives 12-bit pixels over UART as high/low byte pairs.
// It writes each pixel to a frame-buffer address once a start marker has been seen.
module image_receiver
  import image_link_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int NUM_PIXELS   = image_link_pkg::NUM_PIXELS,
  parameter int PAIR_TIMEOUT = 20000
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   uart_in,
  output pixel_t pixel_out,
  output addr_t  address,
  output logic   pixel_valid,
  output logic   frame_done,
  output logic   receiving,
  output logic   frame_error
);

  localparam int TO_W = $clog2(PAIR_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_M1 = TO_W'(PAIR_TIMEOUT - 1);
  localparam addr_t LAST_ADDR = addr_t'(NUM_PIXELS - 1);

  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_frame_err;

  uart_rx #(
    .CLKS_PER_BIT(CLK_FREQ / BAUD_RATE)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (uart_in),
    .byte_out  (w_byte),
    .byte_valid(w_byte_valid),
    .frame_err (w_frame_err)
  );

  logic            r_have_high;
  logic [3:0]      r_hi_nib;
  logic [TO_W-1:0] r_pair_cnt;
  frame_state_t    r_state;
  addr_t           r_next_addr;

  logic   w_pix_valid;
  pixel_t w_pix;

  // An assembled pixel is seen in the same cycle as the low byte's strobe, so the write can register one cycle later
  assign w_pix_valid = w_byte_valid && r_have_high;
  assign w_pix       = {r_hi_nib, w_byte};

  // Pair assembly and pair timeout. Bad stop bits and bad high nibbles set the sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_have_high <= 1'b0;
      r_hi_nib    <= '0;
      r_pair_cnt  <= '0;
      frame_error <= 1'b0;
    end else begin
      if (w_frame_err) begin
        r_have_high <= 1'b0;
        frame_error <= 1'b1;
      end else if (w_byte_valid) begin
        if (r_have_high) begin
          r_have_high <= 1'b0;
        end else if (w_byte[7:4] == 4'h0) begin
          r_have_high <= 1'b1;
          r_hi_nib    <= w_byte[3:0];
          r_pair_cnt  <= '0;
        end else begin
          frame_error <= 1'b1;
        end
      end else if (r_have_high) begin
        // A timed-out high byte is dropped without reporting an error
        if (r_pair_cnt == TO_M1) r_have_high <= 1'b0;
        else                     r_pair_cnt  <= r_pair_cnt + TO_W'(1);
      end
    end
  end

  // Frame FSM: wait for the start marker, write pixels at increasing addresses, then pulse done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_next_addr <= '0;
      pixel_out   <= '0;
      address     <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      receiving   <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pix_valid && (w_pix == START_PIXEL)) begin
            r_state     <= RECEIVE;
            receiving   <= 1'b1;
            address     <= '0;
            r_next_addr <= '0;
          end
        end
        RECEIVE: begin
          if (w_pix_valid) begin
            pixel_valid <= 1'b1;
            pixel_out   <= w_pix;
            address     <= r_next_addr;
            if (r_next_addr == LAST_ADDR) begin
              r_state   <= DONE;
              receiving <= 1'b0;
            end else begin
              r_next_addr <= r_next_addr + addr_t'(1);
            end
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_receiver.sv
// Directed bench for image_receiver. Expected pixel writes are queued when a pixel is sent.
// They are checked against pixel_valid as it happens.
module tb_image_receiver;

  localparam int CF  = 4_000_000;
  localparam int BR  = 100_000;
  localparam int CPB = CF / BR;
  localparam int NP  = 4;
  localparam int PT  = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_in = 1'b1;
  logic [11:0] pixel_out;
  logic [16:0] address;
  logic        pixel_valid;
  logic        frame_done;
  logic        receiving;
  logic        frame_error;

  image_receiver #(
    .CLK_FREQ    (CF),
    .BAUD_RATE   (BR),
    .NUM_PIXELS  (NP),
    .PAIR_TIMEOUT(PT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_in    (uart_in),
    .pixel_out  (pixel_out),
    .address    (address),
    .pixel_valid(pixel_valid),
    .frame_done (frame_done),
    .receiving  (receiving),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          fd_cnt = 0;
  int          bv_cnt = 0;
  logic        exp_fd = 1'b0;
  logic [28:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    uart_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      tick(CPB);
    end
    uart_in = stop;
    tick(CPB);
    uart_in = 1'b1;
    tick(CPB);
  endtask

  task automatic send_pix(input logic [11:0] p, input logic expect_wr, input logic [16:0] a);
    if (expect_wr) sb.push_back({p, a});
    send_byte({4'h0, p[11:8]});
    send_byte(p[7:0]);
    chk("sb_drain", sb.size(), 0);
  endtask

  // Output monitor: check each write against the scoreboard, and check that frame_done follows the last-address write
  always @(negedge clk) begin
    logic [28:0] e;
    if (dut.w_byte_valid) bv_cnt++;
    if (frame_done || exp_fd) chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
    if (frame_done) fd_cnt++;
    exp_fd = 1'b0;
    if (pixel_valid) begin
      n_cmp++;
      assert (sb.size() > 0)
      else begin
        n_err++;
        $error("FAIL unexpected_pixel: observed pix %0h addr %0d expected none", pixel_out, address);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pixel_out", {20'd0, pixel_out}, {20'd0, e[28:17]});
        chk("address", {15'd0, address}, {15'd0, e[16:0]});
        exp_fd = (e[16:0] == 17'(NP - 1));
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pixel_out"}, {20'd0, pixel_out}, 0);
    chk({tag, "_address"}, {15'd0, address}, 0);
    chk({tag, "_pixel_valid"}, {31'd0, pixel_valid}, 0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 0);
    chk({tag, "_receiving"}, {31'd0, receiving}, 0);
    chk({tag, "_frame_error"}, {31'd0, frame_error}, 0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick(3);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick(CPB);

    // A short low glitch on the idle line must not produce a byte
    uart_in = 1'b0;
    tick(15);
    uart_in = 1'b1;
    tick(CPB * 2);
    chk("glitch_bytes", bv_cnt, 0);
    chk("glitch_err", {31'd0, frame_error}, 0);
    chk("glitch_recv", {31'd0, receiving}, 0);

    // Start the frame. After that, 0x00A is written as ordinary data.
    send_pix(12'h00A, 1'b0, 17'd0);
    chk("recv_after_start", {31'd0, receiving}, 1);
    send_pix(12'hF00, 1'b1, 17'd0);
    send_pix(12'h00A, 1'b1, 17'd1);

    // A lone high byte times out, and the next pair is assembled cleanly
    send_byte(8'h0F);
    tick(PT + 200);
    send_pix(12'h055, 1'b1, 17'd2);
    chk("timeout_no_err", {31'd0, frame_error}, 0);

    // Last address: the frame completes and a further pixel is ignored
    send_pix(12'h123, 1'b1, 17'd3);
    chk("done_recv_low", {31'd0, receiving}, 0);
    chk("done_pulses", fd_cnt, 1);
    send_pix(12'h456, 1'b0, 17'd0);
    chk("done_addr_hold", {15'd0, address}, 3);
    chk("done_pulses_after", fd_cnt, 1);

    // A framing error in the middle of a frame loses only the current pair
    send_pix(12'h00A, 1'b0, 17'd0);
    send_pix(12'h111, 1'b1, 17'd0);
    send_byte(8'h01, 1'b0);
    tick(4);
    chk("ferr_flag", {31'd0, frame_error}, 1);
    chk("ferr_addr", {15'd0, address}, 0);
    chk("ferr_recv", {31'd0, receiving}, 1);
    send_pix(12'h222, 1'b1, 17'd1);

    // A high byte with a nonzero upper nibble is dropped
    send_byte(8'h1F);
    send_pix(12'h333, 1'b1, 17'd2);

    // Reset in the middle of a low byte abandons everything
    send_byte(8'h03);
    uart_in = 1'b0;
    tick(CPB);
    uart_in = 1'b1;
    tick(CPB);
    uart_in = 1'b0;
    tick(CPB / 2);
    rst_n = 1'b0;
    uart_in = 1'b1;
    tick(3);
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    tick(CPB * 2);
    send_pix(12'hF00, 1'b0, 17'd0);
    chk("post_rst_idle", {31'd0, receiving}, 0);
    send_pix(12'h00A, 1'b0, 17'd0);
    chk("post_rst_start", {31'd0, receiving}, 1);
    send_pix(12'h789, 1'b1, 17'd0);
    tick(CPB);
    chk("sb_final", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/image_receiver.md
IMAGE_RECEIVER -- requirements
Module: image_receiver

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, meaning the UART line rate.
REQ-003 The block SHALL have parameter NUM_PIXELS, default 76800 (320x240), meaning the number of image pixels per frame.
REQ-004 The block SHALL have parameter PAIR_TIMEOUT, default 20000, meaning the maximum clk cycles from a high byte's stop-bit sample to the following low byte's stop-bit sample.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port uart_in, input, 1 bit: asynchronous serial line, 8N1, idle high.
REQ-008 The block SHALL have port pixel_out, output, 12 bits: received pixel {R[3:0],G[3:0],B[3:0]}.
REQ-009 The block SHALL have port address, output, 17 bits: frame-buffer write address of pixel_out.
REQ-010 The block SHALL have port pixel_valid, output, 1 bit: one-cycle write strobe for pixel_out/address.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last pixel is written.
REQ-012 The block SHALL have port receiving, output, 1 bit: high while in state RECEIVE.
REQ-013 The block SHALL have port frame_error, output, 1 bit: sticky error flag, cleared only by reset.

Function
REQ-014 uart_in SHALL pass through a 2-flop synchronizer; the line is therefore seen 2 cycles late.
REQ-015 The UART receiver SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer, 434 at the defaults).
- It SHALL detect a falling edge, recheck low at CLKS_PER_BIT/2, and sample data LSB-first at mid-bit.
- It SHALL sample the stop bit, then emit byte_valid for 1 cycle.
REQ-016 A start bit that is high at the half-bit recheck SHALL be discarded as a glitch, with no error.
REQ-017 A stop bit sampled low SHALL discard the byte, set frame_error, and reset pair assembly to expect a high byte.
REQ-018 Each pixel SHALL arrive as two bytes: high byte {4'b0000, pixel[11:8]} first, then low byte pixel[7:0].
REQ-019 A high byte with a nonzero upper nibble SHALL be dropped, set frame_error, and leave assembly expecting a high byte.
REQ-020 If the low byte does not complete within PAIR_TIMEOUT cycles of the high byte, the high byte SHALL be discarded and assembly SHALL expect a high byte; frame_error SHALL NOT be set.
REQ-021 Frame FSM states SHALL be IDLE, RECEIVE and DONE.
- IDLE: assembled pixels SHALL be discarded except START_PIXEL = 12'h00A, which SHALL move the FSM to RECEIVE with address=0. No pixel_valid SHALL be issued for START_PIXEL.
- RECEIVE: each assembled pixel SHALL drive pixel_valid=1 for one cycle together with pixel_out and address; address SHALL then increment. 12'h00A SHALL be treated as ordinary data in this state.
- RECEIVE: a pixel written at address NUM_PIXELS-1 SHALL move the FSM to DONE.
- DONE: frame_done=1 for exactly one cycle, then IDLE. address SHALL hold NUM_PIXELS-1; it never wraps.
REQ-022 Latency: pixel_valid SHALL assert the cycle after the low byte's byte_valid.
REQ-023 pixel_out and address SHALL remain stable until the next pixel_valid.
REQ-024 A framing error in RECEIVE SHALL NOT change the FSM state or address; only the current pair is lost.

Reset
REQ-025 While rst_n=0 at a clk edge, the block SHALL set:
- pixel_out=0, address=0, pixel_valid=0, frame_done=0, receiving=0, frame_error=0;
- FSM=IDLE, UART receiver idle, synchronizer flops=1, pair assembly expecting a high byte.
REQ-026 Reset mid-byte or mid-frame SHALL abandon all partial data; no pixel_valid or frame_done SHALL issue from pre-reset bytes.

Structure
REQ-027 A shared package image_link_pkg SHALL hold:
- NUM_PIXELS, START_PIXEL, ADDR_W=17 and PIX_W=12;
- pixel_t and addr_t;
- the frame-state enum.
The transmit side SHALL also import this package.
REQ-028 The UART byte receiver SHALL be a separate sub-module, uart_rx (clk, rst_n, rx, byte_out[7:0], byte_valid, frame_err). Pair assembly, timeout and the frame FSM SHALL live in image_receiver.

Verification
REQ-029 Bytes 00,0A then 0F,00 then 00,0A at BAUD_RATE -> the FSM enters RECEIVE:
- pixel_valid with pixel_out=12'hF00, address=0;
- then pixel_valid with pixel_out=12'h00A, address=1.
REQ-030 NUM_PIXELS=4: start pixel then 4 pixels -> addresses 0..3, frame_done pulses once the cycle after the address-3 write, receiving falls, and a 5th pixel produces no pixel_valid.
REQ-031 Byte 01 with stop bit forced low mid-frame -> frame_error=1, address unchanged; the next valid pair is written at the same address.
REQ-032 Byte 0F followed by idle > PAIR_TIMEOUT, then 00,55 -> one pixel 12'h055; frame_error stays 0.
REQ-033 A 100-cycle low glitch on idle uart_in -> no byte_valid and no error.
REQ-034 rst_n=0 during the low byte of pixel 10 -> all outputs 0 and FSM=IDLE; subsequent data bytes are ignored until 00,0A arrives.
